cnn_data_path_param: RTL

- Parametrised next-generation CNN datapath: accumulator/ALU core, DR/TR/IR, PC/AR address registers, a general-purpose register (GPR) file replacing fixed kernel/feature registers, and a shared internal bus.
- Adds a multi-cycle convolution MAC engine. The engine streams memory operands via AR, multiplies them against GPR kernel weights, and writes a saturated result into AC.
- Sits between the control unit and single-port memory.

---
 rtl/cnn_data_path_param.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_data_path_param.sv
// cnn_data_path_param
//   Parameterised CNN datapath: accumulator/ALU core, DR/TR/IR data registers,
//   PC/AR address registers, a general-purpose register file and a shared bus,
//   plus a multi-cycle convolution MAC engine (IDLE -> RUN -> WB) that streams
//   memory operands through AR, multiplies them by GPR kernel weights and
//   writes the saturated sum into AC.
//
// Optional build macro:
//   MAC_RELU_EN - the MAC write-back value is ReLU(saturate(acc)).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus_sel             bus source (0 DR, 1 AC, 2 TR, 3 PC, 4 mem_rdata,
//                       5 IR, 16+i GPR[i], else 0)
//   *_load, *_inc       register load from bus / increment controls
//   gpr_we, gpr_wsel    GPR write strobe and index
//   ac_load, alu_op     AC <= ALU(AC, DR)
//   mac_start, mac_len  MAC start request and kernel length
//   mac_busy, mac_done  MAC engine active / one-cycle completion pulse
//   mem_addr, mem_rdata, mem_wdata   single-port memory interface
//   ir_value, ac_value, pc_value     register taps
//   flag_z, flag_n      AC zero / negative flags
module cnn_data_path_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int NUM_GPR = 8,
    localparam int LEN_W  = $clog2(NUM_GPR) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        bus_sel,
    input  logic              dr_load,
    input  logic              tr_load,
    input  logic              ir_load,
    input  logic              pc_load,
    input  logic              ar_load,
    input  logic              pc_inc,
    input  logic              ar_inc,
    input  logic              gpr_we,
    input  logic [3:0]        gpr_wsel,
    input  logic              ac_load,
    input  logic [3:0]        alu_op,
    input  logic              mac_start,
    input  logic [LEN_W-1:0]  mac_len,
    output logic              mac_busy,
    output logic              mac_done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ir_value,
    output logic [DATA_W-1:0] ac_value,
    output logic [ADDR_W-1:0] pc_value,
    output logic              flag_z,
    output logic              flag_n
);

    localparam int IDX_W  = $clog2(NUM_GPR);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + LEN_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, WB} mac_state_t;

    mac_state_t                state;
    logic [DATA_W-1:0]         dr, tr, ir, ac;
    logic [ADDR_W-1:0]         pc, ar;
    logic [DATA_W-1:0]         gpr [NUM_GPR];
    logic signed [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]          len, idx, len_clamped;
    logic                      done_r;

    logic [DATA_W-1:0]         bus, alu_res, gpr_rd, sat_val, wb_val;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;

    // Shared bus source select
    always_comb begin
        bus = '0;
        if (bus_sel[4]) begin
            if (int'(bus_sel[3:0]) < NUM_GPR)
                bus = gpr[bus_sel[IDX_W-1:0]];
        end else begin
            case (bus_sel[3:0])
                4'd0:    bus = dr;
                4'd1:    bus = ac;
                4'd2:    bus = tr;
                4'd3:    bus = DATA_W'(pc);
                4'd4:    bus = mem_rdata;
                4'd5:    bus = ir;
                default: bus = '0;
            endcase
        end
    end

    // ALU: a = AC, b = DR
    always_comb begin
        case (alu_op)
            4'd0:    alu_res = ac + dr;
            4'd1:    alu_res = ac - dr;
            4'd2:    alu_res = ac & dr;
            4'd3:    alu_res = ac | dr;
            4'd4:    alu_res = ac ^ dr;
            4'd5:    alu_res = ~ac;
            4'd6:    alu_res = {ac[DATA_W-2:0], 1'b0};
            4'd7:    alu_res = {ac[DATA_W-1], ac[DATA_W-1:1]};
            4'd8:    alu_res = dr;
            4'd9:    alu_res = ac[DATA_W-1] ? '0 : ac;
            4'd10:   alu_res = '0;
            default: alu_res = ac;
        endcase
    end

    // MAC datapath: kernel weight read, signed product, saturation
    always_comb begin
        gpr_rd = '0;
        if (int'(idx) < NUM_GPR)
            gpr_rd = gpr[idx[IDX_W-1:0]];
    end

    assign prod        = $signed(mem_rdata) * $signed(gpr_rd);
    assign prod_ext    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign len_clamped = (int'(mac_len) > NUM_GPR) ? LEN_W'(NUM_GPR) : mac_len;

    always_comb begin
        if (acc > SAT_MAX)
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        else if (acc < SAT_MIN)
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_val = acc[DATA_W-1:0];
`ifdef MAC_RELU_EN
        wb_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        wb_val = sat_val;
`endif
    end

    // MAC sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            len    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (mac_start) begin
                        len   <= len_clamped;
                        acc   <= '0;
                        idx   <= '0;
                        state <= (len_clamped == '0) ? WB : RUN;
                    end
                end
                RUN: begin
                    acc <= acc + prod_ext;
                    idx <= idx + LEN_W'(1);
                    if (idx == len - LEN_W'(1))
                        state <= WB;
                end
                WB: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Architectural registers; AC and AR belong to the MAC while it is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr <= '0;
            tr <= '0;
            ir <= '0;
            ac <= '0;
            pc <= '0;
            ar <= '0;
            for (int unsigned i = 0; i < NUM_GPR; i++)
                gpr[i] <= '0;
        end else begin
            if (dr_load) dr <= bus;
            if (tr_load) tr <= bus;
            if (ir_load) ir <= bus;

            if (pc_load)     pc <= bus[ADDR_W-1:0];
            else if (pc_inc) pc <= pc + ADDR_W'(1);

            if (gpr_we && int'(gpr_wsel) < NUM_GPR)
                gpr[gpr_wsel[IDX_W-1:0]] <= bus;

            if (state == WB)
                ac <= wb_val;
            else if (!mac_busy && ac_load)
                ac <= alu_res;

            if (state == RUN)
                ar <= ar + ADDR_W'(1);
            else if (!mac_busy) begin
                if (ar_load)     ar <= bus[ADDR_W-1:0];
                else if (ar_inc) ar <= ar + ADDR_W'(1);
            end
        end
    end

    assign mac_busy  = (state != IDLE);
    assign mac_done  = done_r;
    assign mem_addr  = ar;
    assign mem_wdata = bus;
    assign ir_value  = ir;
    assign ac_value  = ac;
    assign pc_value  = pc;
    assign flag_z    = (ac == '0);
    assign flag_n    = ac[DATA_W-1];

endmodule
